// File: rtl/serial_adder_pkg.sv
// Shared FSM encodings and width helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int sa_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter must keep at least one bit even when WIDTH=1.
    function automatic int cnt_width(input int width);
        return (sa_clog2(width) < 1) ? 1 : sa_clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_add.sv
// Combinational one-bit full adder cell; zero latency.
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first; done pulses WIDTH+1 cycles after start.
// No backpressure: start is only accepted in IDLE or DONE and is ignored while busy.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_busy;
    logic             w_done;
    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fa_sum;
    logic             w_fa_carry;

    full_add u_full_add (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c     (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_load = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operands shift right so bit 0 always feeds the cell; sum bits enter at the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
            r_carry <= w_fa_carry;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_fa_carry;
            end
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       s8_start = 1'b0;
    logic [7:0] s8_a     = 8'h00;
    logic [7:0] s8_b     = 8'h00;
    logic       s8_cin   = 1'b0;
    logic       d8_busy;
    logic       d8_done;
    logic [7:0] d8_sum;
    logic       d8_cout;

    logic       s1_start = 1'b0;
    logic       s1_a     = 1'b0;
    logic       s1_b     = 1'b0;
    logic       s1_cin   = 1'b0;
    logic       d1_busy;
    logic       d1_done;
    logic       d1_sum;
    logic       d1_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (s8_start),
        .a     (s8_a),
        .b     (s8_b),
        .cin   (s8_cin),
        .busy  (d8_busy),
        .done  (d8_done),
        .sum   (d8_sum),
        .cout  (d8_cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (s1_start),
        .a     (s1_a),
        .b     (s1_b),
        .cin   (s1_cin),
        .busy  (d1_busy),
        .done  (d1_done),
        .sum   (d1_sum),
        .cout  (d1_cout)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Counts rising edges until done is seen at a falling edge; -1 if it never comes.
    task automatic wait_done(input bit w1, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((w1 ? d1_done : d8_done) === 1'b1) begin
                seen = 1'b1;
            end
        end
        if (!seen) begin
            n = -1;
        end
    endtask

    task automatic do_add(input bit w1, input string tag,
                          input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] exp;
        int         n;
        @(negedge clk);
        if (w1) begin
            s1_a     = av[0];
            s1_b     = bv[0];
            s1_cin   = cv;
            s1_start = 1'b1;
            exp      = 9'(av[0]) + 9'(bv[0]) + 9'(cv);
        end else begin
            s8_a     = av;
            s8_b     = bv;
            s8_cin   = cv;
            s8_start = 1'b1;
            exp      = 9'(av) + 9'(bv) + 9'(cv);
        end
        @(posedge clk);
        #1;
        s1_start = 1'b0;
        s8_start = 1'b0;
        wait_done(w1, n);
        check({tag, "_lat"}, 64'(n), w1 ? 64'd1 : 64'd8);
        if (w1) begin
            check({tag, "_res"}, {d1_cout, d1_sum}, 64'(exp));
            check({tag, "_busy"}, d1_busy, 0);
        end else begin
            check({tag, "_res"}, {d8_cout, d8_sum}, 64'(exp));
            check({tag, "_busy"}, d8_busy, 0);
        end
    endtask

    initial begin
        int n;
        int done_seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_busy8", d8_busy, 0);
        check("rst_done8", d8_done, 0);
        check("rst_res8", {d8_cout, d8_sum}, 0);
        check("rst_busy1", d1_busy, 0);
        check("rst_res1", {d1_cout, d1_sum}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_add(0, "zero", 8'h00, 8'h00, 1'b0);
        do_add(0, "ff_01", 8'hFF, 8'h01, 1'b0);
        do_add(0, "ff_ff_c", 8'hFF, 8'hFF, 1'b1);

        // Result holds in IDLE.
        repeat (2) @(negedge clk);
        check("hold_res", {d8_cout, d8_sum}, 9'h1FF);
        check("hold_done", d8_done, 0);

        // Second start mid-RUN must be ignored.
        @(negedge clk);
        s8_a = 8'h5A; s8_b = 8'h3C; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1 s8_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s8_a = 8'h01; s8_b = 8'h00; s8_start = 1'b1;
        @(posedge clk);
        #1 s8_start = 1'b0;
        wait_done(0, n);
        check("midrun_lat", 64'(n), 5);
        check("midrun_res", {d8_cout, d8_sum}, 9'h096);
        @(negedge clk);
        check("midrun_norestart", d8_busy, 0);

        // start held high: back-to-back additions.
        @(negedge clk);
        s8_a = 8'h12; s8_b = 8'h34; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8_a = 8'h80; s8_b = 8'h80;
        wait_done(0, n);
        check("b2b_lat1", 64'(n), 8);
        check("b2b_res1", {d8_cout, d8_sum}, 9'h046);
        wait_done(0, n);
        check("b2b_gap", 64'(n), 9);
        check("b2b_res2", {d8_cout, d8_sum}, 9'h100);
        s8_start = 1'b0;
        @(negedge clk);
        check("b2b_pulse", d8_done, 0);

        // Reset on the 4th RUN cycle aborts with no done pulse.
        @(negedge clk);
        s8_a = 8'h07; s8_b = 8'h00; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1 s8_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_pre_sum", d8_sum, 8'hE0);
        check("abort_pre_busy", d8_busy, 1);
        rst = 1'b1;
        s8_start = 1'b1;
        #1;
        check("abort_busy", d8_busy, 0);
        check("abort_done", d8_done, 0);
        check("abort_res", {d8_cout, d8_sum}, 0);
        @(posedge clk);
        @(negedge clk);
        check("abort_start_ign", d8_busy, 0);
        rst = 1'b0;
        s8_start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d8_done === 1'b1) done_seen++;
        end
        check("abort_nodone", 64'(done_seen), 0);

        do_add(0, "post_rst", 8'h21, 8'h43, 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = 8'(i & 1);
            rb = 8'((i >> 1) & 1);
            rc = 1'(i >> 2);
            do_add(1, "w1_dir", ra, rb, rc);
        end

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            do_add(0, "rnd8", ra, rb, rc);
            do_add(1, "rnd1", ra, rb, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin one addition, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, sampled only when start is accepted.
REQ-007 The block SHALL have port cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while bits are being processed.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking sum/cout valid.
REQ-010 The block SHALL have port sum  output  WIDTH  registered result a+b+cin mod 2^WIDTH.
REQ-011 The block SHALL have port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE, with IDLE entered from reset.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL capture a, b and cin, clear the bit counter and the sum shift register, and enter RUN.
REQ-014 In RUN, start SHALL be ignored and the operand inputs SHALL NOT be resampled.
REQ-015 Each RUN edge SHALL process exactly one bit, LSB first, through one full-adder cell: sum bit into the MSB of the right-shifting sum register, carry into the carry flip-flop.
REQ-016 The carry flip-flop SHALL be loaded with cin on start acceptance and SHALL feed the carry input of the cell on every RUN cycle.
REQ-017 After the WIDTH-th RUN edge, the FSM SHALL enter DONE; sum and cout SHALL hold the final result from that edge onward.
REQ-018 Latency SHALL be fixed: start accepted at edge E0 gives done=1 in the cycle following edge E(WIDTH), independent of the operand values.
REQ-019 busy SHALL be 1 exactly in RUN, and done SHALL be 1 exactly in DONE, which lasts one cycle.
REQ-020 DONE SHALL go to IDLE on the next edge if start=0, or directly to RUN if start=1, so back-to-back additions are possible with no idle gap.
REQ-021 sum and cout SHALL hold their last values in IDLE until the next start is accepted.
REQ-022 When WIDTH=1, RUN SHALL last one cycle and the same rules SHALL apply.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0 and counter=0, without waiting for a clock edge.
REQ-024 Asserting rst during RUN SHALL abort the addition with no done pulse, and start SHALL be ignored while rst=1.
REQ-025 After rst deasserts, the first start SHALL behave as in REQ-013.

Structure
REQ-026 State encodings (IDLE, RUN, DONE) SHALL be defined as constants in the shared package serial_adder_pkg.
REQ-027 The one-bit adder SHALL be the existing combinational full_add cell, instantiated once, with ports a, b, c, sum and carry.
REQ-028 The counter width SHALL be derived from WIDTH by a clog2 function.

Verification
REQ-029 With WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, done high exactly 9 cycles after the start edge.
REQ-030 With WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, and a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 With WIDTH=8, a=0x5A, b=0x3C, start pulsed again mid-RUN with a=0x01 -> result 0x96, cout=0, and the second start is ignored.
REQ-032 With WIDTH=8, start held high -> consecutive results 0x12+0x34=0x46 then 0x80+0x80=0x00 with cout=1, done pulses 9 cycles apart.
REQ-033 Asserting rst on the 4th RUN cycle -> busy, done, sum and cout become 0 at once, with no done pulse.
REQ-034 The bench SHALL run a randomized sweep of 200 vectors at WIDTH=1 and WIDTH=8, checking {cout,sum} against a+b+cin.
